// File: rtl/chronos_fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The queue side uses the slave modport; the fetch/decode side uses master.
interface chronos_fetch_queue_if #(
  parameter int PTR_W = 2
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic [PTR_W:0]   count;

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );
endinterface

// File: rtl/chronos_fetch_queue.sv
// Circular {pc, inst} FIFO between fetch and decode with flush on redirect.
// Optional same-cycle bypass when empty: define CHRONOS_FETCH_QUEUE_BYPASS_EN.
module chronos_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic                   clk,
  input logic                   rst,
  chronos_fetch_queue_if.slave  bus
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [63:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic empty;
  logic push;
  logic pop;
  logic [63:0] head;

  assign empty        = (count == '0);
  assign head         = mem[rd_ptr];
  assign bus.in_ready = (count != FULL_COUNT);
  assign bus.count    = count;

`ifdef CHRONOS_FETCH_QUEUE_BYPASS_EN
  logic bypass;

  // An empty queue forwards the incoming instruction straight to decode;
  // it is only stored if decode does not take it this cycle.
  assign bypass        = empty & bus.in_valid & ~bus.flush;
  assign bus.out_valid = ~empty | bypass;
  assign bus.out_pc    = bypass ? bus.in_pc   : head[63:32];
  assign bus.out_inst  = bypass ? bus.in_inst : head[31:0];
  assign push = bus.in_valid & bus.in_ready & ~bus.flush & ~(bypass & bus.out_ready);
  assign pop  = ~empty & bus.out_ready & ~bus.flush;
`else
  assign bus.out_valid = ~empty;
  assign bus.out_pc    = head[63:32];
  assign bus.out_inst  = head[31:0];
  assign push = bus.in_valid & bus.in_ready & ~bus.flush;
  assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;
`endif

  // Storage is cleared on reset so the head read is never X while empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bus.in_pc, bus.in_inst};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/chronos_fetch_queue.md
Name: chronos_fetch_queue

Overview:
- Instruction fetch queue between the fetch stage (PC register plus instruction memory) and the decode stage of the Chronos RV32I core.
- Buffers {pc, inst} pairs in a small circular FIFO with a valid/ready handshake on each side, so decode stalls do not force fetch to recompute the PC.
- A flush input discards all buffered instructions on a branch or jump redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; rst==0 at a rising clk edge resets the block.
- flush  input  1  discard all entries and any push in the same cycle.
- in_valid  input  1  fetch presents a valid {in_pc, in_inst}.
- in_ready  output  1  queue can accept a push this cycle.
- in_pc  input  32  PC of the fetched instruction.
- in_inst  input  32  fetched instruction word.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  PC of the head entry.
- out_inst  output  32  instruction word of the head entry.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage and pointers:
  - Storage is DEPTH x 64 bits ({pc, inst}) plus wr_ptr, rd_ptr (PTR_W bits each) and a count register (PTR_W+1 bits).
  - Pointers wrap modulo DEPTH (DEPTH-1 -> 0).
- Push and pop conditions:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH):
  - Depends only on registered state; no combinational path from out_ready.
  - When full, in_ready=0 even if a pop occurs in the same cycle.
- Outputs:
  - out_valid = (count != 0).
  - out_pc and out_inst are a combinational read of entry[rd_ptr].
  - With count==0 their value is don't-care, but they must not be X after reset; storage resets to 0.
- Per-cycle update:
  - Push only: write entry[wr_ptr], wr_ptr+1, count+1.
  - Pop only: rd_ptr+1, count-1.
  - Push and pop together (count between 1 and DEPTH-1): both pointers advance, count is unchanged.
  - Push into an empty queue: data appears on out_* the next cycle. Latency is 1 cycle from accepted push to out_valid.
- Flush:
  - wr_ptr=0, rd_ptr=0, count=0 on the next edge.
  - Same-cycle push and pop are ignored; storage contents may remain.
  - out_valid=0 from the cycle after flush.
- Reset (rst==0 at the edge):
  - wr_ptr=0, rd_ptr=0, count=0, all storage 0, so out_valid=0, out_pc=0, out_inst=0, in_ready=1.
  - Reset takes priority over flush, push and pop.
  - Reset mid-stream discards all contents.
- Ordering: strict FIFO order; no entry is duplicated or dropped except by flush or reset.
- Overflow and underflow:
  - in_valid while in_ready=0 has no effect; fetch must hold its data.
  - out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: CHRONOS_FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and in_valid=1 and flush=0, out_valid=1 in the same cycle, and out_pc/out_inst come combinationally from in_pc/in_inst.
  - If out_ready=1 in that cycle, the instruction is consumed without being written: pointers and count are unchanged.
  - If out_ready=0, it is written normally, as a push.
  - Zero-cycle latency when empty.
- Undefined: no bypass; the minimum push-to-out_valid latency is 1 cycle; out_* depend only on registered state.

Test Plan:
1. Reset then fill:
   - Stimulus: hold rst=0 for 2 cycles, release; out_ready=0; push pc=0x00,0x04,0x08,0x0C with inst=0x00000013.
   - Response: count=1,2,3,4; in_ready=0 after the 4th push; a 5th push (pc=0x10) is not accepted and count stays 4.
2. Drain in order:
   - Stimulus: from full, out_ready=1 and in_valid=0 for 4 cycles.
   - Response: out_pc=0x00,0x04,0x08,0x0C in order; out_valid=0 and count=0 afterwards.
3. Simultaneous push and pop:
   - Stimulus: count=2, in_valid=1 and out_ready=1 for 6 cycles with pc incrementing by 4.
   - Response: count stays 2; pointers wrap past DEPTH-1; output order matches input order.
4. Flush with push:
   - Stimulus: count=3, assert flush together with in_valid=1 (pc=0x40).
   - Response: next cycle count=0, out_valid=0, in_ready=1; 0x40 never appears on out_pc.
5. Reset mid-stream:
   - Stimulus: count=2, rst=0 for one edge while in_valid=1 and out_ready=1.
   - Response: count=0, out_pc=0, out_inst=0, out_valid=0, in_ready=1.
6. Bypass:
   - Stimulus: empty queue, in_valid=1, out_ready=1, pc=0x100, inst=0x00500093.
   - Response with CHRONOS_FETCH_QUEUE_BYPASS_EN: out_valid=1 and out_pc=0x100 in the same cycle, count stays 0.
   - Response without it: out_valid=1 on the next cycle, count=1.
